// File: rtl/alarm_set_entry.sv
// Alarm-time entry: mode/inc buttons edit a shadow HH:MM copy, committed on the last mode press.
// Editing is abandoned after ten idle seconds.
module alarm_set_entry #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic              tick_1hz,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] d3,
  output logic              editing,
  output logic [1:0]        sel
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EDIT_HT = 3'd1;
  localparam logic [2:0] EDIT_HU = 3'd2;
  localparam logic [2:0] EDIT_MT = 3'd3;
  localparam logic [2:0] EDIT_MU = 3'd4;

  logic [2:0]        state, state_n;
  logic [DATA_W-1:0] s0, s1, s2, s3;
  logic [DATA_W-1:0] s0_n, s1_n, s2_n, s3_n;
  logic [DATA_W-1:0] a0_n, a1_n, a2_n, a3_n;
  logic [3:0]        tcnt, tcnt_n;
  logic              mode_btn_p1, inc_btn_p1;
  logic              mode_edge, inc_edge;

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v,
                                                 input logic [DATA_W-1:0] maxv);
    return (v >= maxv) ? '0 : v + 1'b1;
  endfunction

  assign mode_edge = mode_btn & ~mode_btn_p1;
  assign inc_edge  = inc_btn & ~inc_btn_p1;

  always_comb begin
    state_n = state;
    s0_n = s0; s1_n = s1; s2_n = s2; s3_n = s3;
    a0_n = a0; a1_n = a1; a2_n = a2; a3_n = a3;
    tcnt_n = tcnt;
    case (state)
      IDLE: begin
        if (mode_edge) begin
          state_n = EDIT_HT;
          s0_n = a0; s1_n = a1; s2_n = a2; s3_n = a3;
          tcnt_n = '0;
        end
      end
      EDIT_HT, EDIT_HU, EDIT_MT, EDIT_MU: begin
        // Mode wins over inc; either edge restarts the inactivity timer.
        if (mode_edge) begin
          tcnt_n = '0;
          case (state)
            EDIT_HT: state_n = EDIT_HU;
            EDIT_HU: state_n = EDIT_MT;
            EDIT_MT: state_n = EDIT_MU;
            default: begin
              state_n = IDLE;
              a0_n = s0; a1_n = s1; a2_n = s2; a3_n = s3;
            end
          endcase
        end else if (inc_edge) begin
          tcnt_n = '0;
          case (state)
            EDIT_HT: begin
              s3_n = wrap_inc(s3, DATA_W'(2));
              if (s3_n == DATA_W'(2) && s2 > DATA_W'(3)) s2_n = DATA_W'(3);
            end
            EDIT_HU: s2_n = wrap_inc(s2, (s3 == DATA_W'(2)) ? DATA_W'(3) : DATA_W'(9));
            EDIT_MT: s1_n = wrap_inc(s1, DATA_W'(5));
            default: s0_n = wrap_inc(s0, DATA_W'(9));
          endcase
        end else if (tick_1hz) begin
          if (tcnt == 4'd9) begin
            state_n = IDLE;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a0 <= '0; a1 <= '0; a2 <= '0; a3 <= '0;
      s0 <= '0; s1 <= '0; s2 <= '0; s3 <= '0;
      tcnt <= '0;
      mode_btn_p1 <= 1'b1;
      inc_btn_p1  <= 1'b1;
    end else begin
      state <= state_n;
      a0 <= a0_n; a1 <= a1_n; a2 <= a2_n; a3 <= a3_n;
      s0 <= s0_n; s1 <= s1_n; s2 <= s2_n; s3 <= s3_n;
      tcnt <= tcnt_n;
      mode_btn_p1 <= mode_btn;
      inc_btn_p1  <= inc_btn;
    end
  end

  assign editing = (state != IDLE);
  assign d0 = editing ? s0 : a0;
  assign d1 = editing ? s1 : a1;
  assign d2 = editing ? s2 : a2;
  assign d3 = editing ? s3 : a3;

  always_comb begin
    case (state)
      EDIT_HT: sel = 2'd3;
      EDIT_HU: sel = 2'd2;
      EDIT_MT: sel = 2'd1;
      default: sel = 2'd0;
    endcase
  end

endmodule

// File: doc/alarm_set_entry.md
ALARM_SET_ENTRY -- requirements
Module: alarm_set_entry

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 mode_btn  input  1  debounced level; rising edge enters edit mode or advances the edit field.
REQ-005 inc_btn  input  1  debounced level; rising edge increments the selected field.
REQ-006 tick_1hz  input  1  one-clk-wide pulse once per second; timeout timebase.
REQ-007 a0, a1, a2, a3  output  6 each  committed alarm digits: a0 = minute units, a1 = minute tens, a2 = hour units, a3 = hour tens; unsigned binary.
REQ-008 d0, d1, d2, d3  output  6 each  display digits: shadow digits while editing, committed digits otherwise.
REQ-009 editing  output  1  high in any EDIT_* state.
REQ-010 sel  output  2  selected field in edit mode (3 = HT, 2 = HU, 1 = MT, 0 = MU); 0 when idle.

Function
REQ-011 Edge detect SHALL use one registered copy per button; an edge is current=1 and previous=0; one press SHALL give one action however long it is held.
REQ-012 FSM states SHALL be IDLE, EDIT_HT, EDIT_HU, EDIT_MT, EDIT_MU.
REQ-013 IDLE + mode edge SHALL go to EDIT_HT and copy a3..a0 into shadow s3..s0 in the same cycle.
REQ-014 A mode edge SHALL advance EDIT_HT->EDIT_HU->EDIT_MT->EDIT_MU.
REQ-015 EDIT_MU + mode edge SHALL go to IDLE and commit s3..s0 to a3..a0 on that clock edge, so the new a* values are visible in the next cycle.
REQ-016 a3..a0 SHALL change only on commit or reset.
REQ-017 An inc edge in IDLE SHALL be ignored.
REQ-018 Increment ranges: HT 0->1->2->0; HU 0..9 wrapping to 0, but 0..3 wrapping to 0 when s3 = 2; MT 0..5 wrapping to 0; MU 0..9 wrapping to 0.
REQ-019 When HT increments to 2 and s2 > 3, s2 SHALL be clamped to 3 in the same cycle.
REQ-020 If mode and inc edges occur in the same cycle, mode SHALL take effect and inc SHALL be ignored.
REQ-021 An inc edge SHALL update the shadow digit on the clock edge that detects it, with 1-cycle latency to the d* outputs.
REQ-022 Timeout counter SHALL be 4 bits, cleared on entry to edit mode and on every mode or inc edge, and incremented on each tick_1hz while editing.
REQ-023 When the timeout count reaches 10 with no button edge in that cycle, the block SHALL return to IDLE, discard the shadow digits, and leave a* unchanged.
REQ-024 A button edge in the same cycle as the 10th tick SHALL take precedence; the counter clears and editing continues.
REQ-025 Committed and shadow digit values SHALL always stay within the legal ranges: hours 00..23, minutes 00..59.

Reset
REQ-026 On reset the block SHALL set: state IDLE; a3..a0 = 0,0,0,0 (00:00); shadow digits = 0; timeout counter = 0; editing = 0; sel = 0.
REQ-027 On reset both button-history registers SHALL be set to 1, so a button held through reset gives no edge until it is released and pressed again.
REQ-028 Reset asserted during editing SHALL discard the shadow digits, and reset SHALL override all other inputs in the same cycle.

Verification
REQ-029 After reset, press mode x1, inc x1 (HT=1), mode, inc x2 (HU=2), mode, inc x3 (MT=3), mode, inc x4 (MU=4), mode -> a3..a0 = 1,2,3,4 one cycle after the final mode edge; editing = 0.
REQ-030 Wrap/clamp: shadow 1,9 (19:xx); in EDIT_HT press inc x1 -> s3 = 2, s2 = 3; in EDIT_HU press inc x1 -> s2 = 0.
REQ-031 Timeout: enter edit, change MU, then 10 tick_1hz pulses with no presses -> IDLE, editing = 0, a* unchanged, d* = a*.
REQ-032 In EDIT_MT assert the mode and inc edges in the same cycle -> state EDIT_MU, s1 unchanged.
REQ-033 Hold inc high for 50 cycles in EDIT_MU -> s0 increments exactly once.
REQ-034 Assert reset in EDIT_HU with modified shadow digits -> next cycle: IDLE, a* = 0, held mode_btn gives no edge until it is released.
